// File: rtl/data_sram_resp_pkg.sv
// Shared types and widths for the data-SRAM responder: FSM states,
// write-enable bus width and wait-state counter width.
package data_sram_resp_pkg;

    localparam int DataSramWenBus = 4;
    localparam int WaitCntWidth   = 4;
    localparam int LaneWidth      = 8;

    typedef enum logic {
        DSR_IDLE = 1'b0,
        DSR_WAIT = 1'b1
    } dsr_state_e;

endpackage

// File: rtl/data_sram_resp_bank.sv
// One byte lane of the data SRAM: synchronous write with enable, and a
// registered read that only updates when a read is requested.
module sram_bank_byte #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [7:0]            wdata_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [2**DEPTH_LOG2];
    logic [7:0] rdata_q;

    // The read register holds its value across writes so the last loaded
    // word stays visible to MEM until the next read commits.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-lane writes, registered read word one cycle after
// commit, optional wait states with a stall request, sticky range error.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_sram_en,
    input  logic [DataSramWenBus-1:0] data_sram_wen,
    input  logic [31:0]               data_sram_addr,
    input  logic [31:0]               data_sram_wdata,
    output logic [31:0]               data_sram_rdata,
    output logic                      stallreq_for_mem,
    output logic                      addr_err
);

    localparam logic                    HasWait = (WAIT_CYCLES != 0);
    localparam logic [WaitCntWidth-1:0] CntLoad =
        (WAIT_CYCLES == 0) ? '0 : WaitCntWidth'(WAIT_CYCLES - 1);

    dsr_state_e              state_q, state_d;
    logic [WaitCntWidth-1:0] cnt_q, cnt_d;
    logic                    addrErr_q;
    logic                    rdZero_q;

    logic                      commit;
    logic                      stallReq;
    logic                      isWrite;
    logic                      inRange;
    logic [DEPTH_LOG2-1:0]     wordIdx;
    logic [DataSramWenBus-1:0] bankWe;
    logic                      bankRe;
    logic [31:0]               bankRdata;
    logic                      unusedAddrBits;

    assign wordIdx        = data_sram_addr[DEPTH_LOG2+1:2];
    assign inRange        = (data_sram_addr[31:DEPTH_LOG2+2] == ADDR_BASE[31:DEPTH_LOG2+2]);
    assign isWrite        = |data_sram_wen;
    assign unusedAddrBits = ^data_sram_addr[1:0];

    // Request sequencing: commit immediately with no wait states, otherwise
    // count down in WAIT and commit on the edge that leaves it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        stallReq = 1'b0;
        case (state_q)
            DSR_IDLE: begin
                if (data_sram_en) begin
                    if (HasWait) begin
                        state_d  = DSR_WAIT;
                        cnt_d    = CntLoad;
                        stallReq = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            DSR_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - 1'b1;
                    stallReq = 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = DSR_IDLE;
                end
            end
        endcase
        if (rst) begin
            commit   = 1'b0;
            stallReq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DSR_IDLE;
            cnt_q     <= '0;
            addrErr_q <= 1'b0;
            rdZero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit && !inRange) begin
                addrErr_q <= 1'b1;
            end
            // rdZero_q masks the bank output after reset and out-of-range reads.
            if (commit && !isWrite) begin
                rdZero_q <= !inRange;
            end
        end
    end

    assign bankWe = (commit && inRange) ? data_sram_wen : '0;
    assign bankRe = commit && inRange && !isWrite;

    for (genvar lane = 0; lane < DataSramWenBus; lane++) begin : gLane
        sram_bank_byte #(
            .DEPTH_LOG2(DEPTH_LOG2)
        ) uBank (
            .clk    (clk),
            .we_i   (bankWe[lane]),
            .re_i   (bankRe),
            .addr_i (wordIdx),
            .wdata_i(data_sram_wdata[LaneWidth*lane +: LaneWidth]),
            .rdata_o(bankRdata[LaneWidth*lane +: LaneWidth])
        );
    end

    assign data_sram_rdata  = rdZero_q ? 32'h0 : bankRdata;
    assign stallreq_for_mem = stallReq;
    assign addr_err         = addrErr_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: a zero-wait and a three-wait instance, each
// checked every cycle against a transaction-level memory model.
module tb_data_sram_resp;

    logic        clk;
    logic        rst0, en0, stall0, err0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        rst3, en3, stall3, err3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;

    logic [31:0] expRdata0, expRdata3;
    logic        expErr0, expErr3, expStall0, expStall3;
    logic [31:0] mem0 [int];
    logic [31:0] mem3 [int];
    bit          checkEn;
    int          vectors;
    int          fails;
    int          stallSeen3;
    int          stallBefore;

    data_sram_resp #(.DEPTH_LOG2(12), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
        .clk(clk), .rst(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
        .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
        .stallreq_for_mem(stall0), .addr_err(err0)
    );

    data_sram_resp #(.DEPTH_LOG2(12), .WAIT_CYCLES(3), .ADDR_BASE(32'h0)) dut3 (
        .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .stallreq_for_mem(stall3), .addr_err(err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: one word per index, base 0, 4096 words.
    task automatic commitModel(input bit sel, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
        bit          inRange;
        int          idx;
        logic [31:0] word;
        inRange = ((addr >> 14) == 0);
        idx     = int'((addr >> 2) % 4096);
        if (sel) word = mem3.exists(idx) ? mem3[idx] : 32'h0;
        else     word = mem0.exists(idx) ? mem0[idx] : 32'h0;
        if (!inRange) begin
            if (sel) expErr3 = 1'b1; else expErr0 = 1'b1;
            if (wen == 4'b0) begin
                if (sel) expRdata3 = 32'h0; else expRdata0 = 32'h0;
            end
        end else if (wen == 4'b0) begin
            if (sel) expRdata3 = word; else expRdata0 = word;
        end else begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) word[8*b +: 8] = wdata[8*b +: 8];
            if (sel) mem3[idx] = word; else mem0[idx] = word;
        end
    endtask

    // Drives one request at posedge+1 and returns at posedge+1 after its commit.
    task automatic applyStimulus(input bit sel, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (!sel) begin
            en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
            expStall0 = 1'b0;
            @(posedge clk); #1;
            commitModel(1'b0, wen, addr, wdata);
            en0 = 1'b0; wen0 = 4'b0;
        end else begin
            en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
            expStall3 = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            expStall3 = 1'b0;
            @(posedge clk); #1;
            commitModel(1'b1, wen, addr, wdata);
            en3 = 1'b0; wen3 = 4'b0;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rdata0", rdata0, expRdata0);
            checkOutput("stall0", {31'b0, stall0}, {31'b0, expStall0});
            checkOutput("err0",   {31'b0, err0},   {31'b0, expErr0});
            checkOutput("rdata3", rdata3, expRdata3);
            checkOutput("stall3", {31'b0, stall3}, {31'b0, expStall3});
            checkOutput("err3",   {31'b0, err3},   {31'b0, expErr3});
            if (stall3) stallSeen3++;
        end
    end

    initial begin
        vectors = 0; fails = 0; stallSeen3 = 0; checkEn = 1'b0;
        rst0 = 1'b1; en0 = 1'b0; wen0 = 4'b0; addr0 = 32'h0; wdata0 = 32'h0;
        rst3 = 1'b1; en3 = 1'b0; wen3 = 4'b0; addr3 = 32'h0; wdata3 = 32'h0;
        expRdata0 = 32'h0; expRdata3 = 32'h0;
        expErr0 = 1'b0; expErr3 = 1'b0; expStall0 = 1'b0; expStall3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;
        checkEn = 1'b1;
        checkOutput("resetRdata0", rdata0, 32'h0);
        checkOutput("resetRdata3", rdata3, 32'h0);
        checkOutput("resetErr0", {31'b0, err0}, 32'h0);
        checkOutput("resetStall3", {31'b0, stall3}, 32'h0);

        $display("[TB] zero-wait write then read");
        applyStimulus(1'b0, 4'b1111, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'b0000, 32'h10, 32'h0);
        checkOutput("rd10", rdata0, 32'hDEADBEEF);

        $display("[TB] byte merge");
        applyStimulus(1'b0, 4'b1111, 32'h20, 32'h11223344);
        applyStimulus(1'b0, 4'b0100, 32'h20, 32'h00AA0000);
        applyStimulus(1'b0, 4'b0000, 32'h22, 32'h0);
        checkOutput("merge20", rdata0, 32'h11AA3344);

        $display("[TB] out of range");
        applyStimulus(1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);
        applyStimulus(1'b0, 4'b1111, 32'h0001_0000, 32'h55555555);
        applyStimulus(1'b0, 4'b0000, 32'h0001_0000, 32'h0);
        checkOutput("oorRdata", rdata0, 32'h0);
        checkOutput("oorErr", {31'b0, err0}, 32'h1);
        applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
        checkOutput("mem0Kept", rdata0, 32'hCAFEF00D);

        $display("[TB] back-to-back reads");
        applyStimulus(1'b0, 4'b0000, 32'h10, 32'h0);
        checkOutput("b2b10", rdata0, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'b0000, 32'h20, 32'h0);
        checkOutput("b2b20", rdata0, 32'h11AA3344);
        checkOutput("errSticky", {31'b0, err0}, 32'h1);

        $display("[TB] three wait states");
        applyStimulus(1'b1, 4'b1111, 32'h30, 32'h0);
        applyStimulus(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
        stallBefore = stallSeen3;
        applyStimulus(1'b1, 4'b0000, 32'h10, 32'h0);
        checkOutput("w3Rd10", rdata3, 32'hDEADBEEF);
        checkOutput("w3StallCycles", 32'(stallSeen3 - stallBefore), 32'd3);

        $display("[TB] reset in second wait cycle");
        en3 = 1'b1; wen3 = 4'b1111; addr3 = 32'h30; wdata3 = 32'h12345678;
        expStall3 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst3 = 1'b1; expStall3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0; en3 = 1'b0; wen3 = 4'b0;
        expRdata3 = 32'h0; expErr3 = 1'b0;
        checkOutput("rstStall", {31'b0, stall3}, 32'h0);
        checkOutput("rstRdata", rdata3, 32'h0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 4'b0000, 32'h30, 32'h0);
        checkOutput("rd30AfterRst", rdata3, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the data-SRAM interface driven by EX and consumed by MEM. It accepts the pipeline's data_sram request (enable, byte write-enables, address, write data) and performs byte-lane writes. For reads it returns a registered word on data_sram_rdata one cycle after the request is committed, which is the cycle the load sits in MEM. A programmable wait-state counter lets it raise a stall request so the core can be exercised against a slow memory.

## Interface
- DEPTH_LOG2, 12: word-address bits; storage is 2^DEPTH_LOG2 × 32 bits.
- WAIT_CYCLES, 0: stall cycles inserted per request (0 to 15).
- ADDR_BASE, 32'h0000_0000: base address, which must be aligned to 2^(DEPTH_LOG2+2).

- clk  in  1  clock. One clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- data_sram_en  in  1  request valid.
- data_sram_wen  in  4  byte write-enables; lane i is bits [8i+7:8i]. 0000 means read.
- data_sram_addr  in  32  byte address; bits [1:0] are ignored.
- data_sram_wdata  in  32  store data, already lane-aligned by EX.
- data_sram_rdata  out  32  registered read word.
- stallreq_for_mem  out  1  combinational stall request to the stall controller.
- addr_err  out  1  sticky flag: an out-of-range access occurred.

## Operation
- Word index = addr[DEPTH_LOG2+1:2].
- An access is in range when addr[31:DEPTH_LOG2+2] equals the same bits of ADDR_BASE.
- State machine, encoded in 1 bit:
  - IDLE: data_sram_en=1 accepts a request.
    - If WAIT_CYCLES==0, the request commits at this edge.
    - Otherwise, load cnt=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: while cnt!=0, decrement cnt.
    - When cnt==0, the request commits at this edge and the state returns to IDLE.
    - Inputs are not re-sampled; the stalled pipeline holds them stable.
- Commit:
  - Write (wen!=0): for each i with wen[i]=1, mem[idx] lane i is written with wdata lane i. Other lanes are unchanged. data_sram_rdata is unchanged.
  - Read (wen==0): data_sram_rdata is set to mem[idx].
  - Out of range: a write is dropped; a read returns 32'h0. Either sets addr_err.
- Each request commits exactly once.
- stallreq_for_mem = !rst & ((IDLE & en & WAIT_CYCLES!=0) | (WAIT & cnt!=0)).
- Sign/zero extension and byte select are done in MEM, not here. rdata is always the full word.

## Timing
- Reset values: state=IDLE, cnt=0, data_sram_rdata=32'h0, addr_err=0, stallreq_for_mem=0. Memory contents are not cleared.
- Read latency with zero waits: request in cycle T, rdata valid from T+1, held until the next read commit.
- Read latency with W waits: stall is high in cycles T..T+W-1. Commit happens at the end of T+W. rdata is valid at T+W+1, which is the cycle the load reaches MEM.
- Back-to-back requests in IDLE (W=0): one per cycle.
  - A read of a word written in the previous cycle returns the new data, because the write committed earlier.
  - A write followed by a read of the same index in consecutive cycles returns the written bytes merged with the old bytes.
- A new request is not accepted in the cycle a WAIT ends. The pipeline only advances after stall drops, so the next request arrives in the following IDLE cycle.
- Reset mid-WAIT: the pending request is discarded (no write, rdata=0), and the state returns to IDLE.
- rst has priority over every other event.
- addr_err clears only on rst.

## Structure
- defines.vh gets:
  - state encodings `DSR_IDLE and `DSR_WAIT;
  - `DataSramWenBus (4);
  - the WAIT_CYCLES counter width (4).
- Sub-module sram_bank_byte: one 8-bit-wide, 2^DEPTH_LOG2-deep synchronous RAM with write-enable and registered read. It is instantiated four times, one per lane.
- The top level holds the state machine, counter, range check, rdata mux and addr_err.

## Test plan
- W=0, write 32'hDEADBEEF with wen=1111 to 0x10, then read 0x10 next cycle → rdata=DEADBEEF at the cycle after the read. stall is never asserted.
- Byte merge: pre-load 0x20 with 11223344; write wen=0100, wdata=00AA0000; read → 11AA3344.
- W=3, read 0x10: stall high for exactly 3 cycles, rdata=DEADBEEF one cycle after stall falls. A single commit is confirmed by an unchanged write count.
- Out of range: ADDR_BASE=0, DEPTH_LOG2=12, write to 0x0001_0000, then read 0x0001_0000 → rdata=0, addr_err=1. mem[0] is unchanged.
- rst asserted in the second WAIT cycle of a W=3 write to 0x30 (old value 0) → stall=0 next cycle, rdata=0, a later read of 0x30 returns 0.
- W=0 back-to-back reads of 0x10 then 0x20 → rdata=DEADBEEF, then 11AA3344 on consecutive cycles.
